// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: operator codes, engine states
// and the BCD digit type.
package calc_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_EQ   = 3'd2;
    localparam logic [2:0] OP_CLR  = 3'd3;
    localparam logic [2:0] OP_BKSP = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDP = 2'd1,
        ST_NEGP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_alu.sv
// Combinational single-digit BCD adder/subtractor; cin/cout act as carry when
// adding and as borrow when subtracting.
module bcd_digit_alu
    import calc_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       sub,
    input  logic       cin,
    output bcd_digit_t y,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
        y    = '0;
        cout = 1'b0;
        if (sub) begin
            // Operands are valid digits, so a negative difference is at least -10.
            if (diff[4]) begin
                y    = diff[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                y    = diff[3:0];
            end
        end else begin
            if (sum > 5'd9) begin
                y    = 4'(sum - 5'd10);
                cout = 1'b1;
            end else begin
                y    = sum[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_accumulator.sv
// Decimal entry-and-accumulate engine with digit-serial signed BCD add/subtract.
// Backspace support is compiled in with CALC_BACKSPACE_EN.
module bcd_accumulator
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dig_vld,
    input  logic [3:0]                   dig,
    input  logic                         op_vld,
    input  logic [2:0]                   op,
    output logic                         busy,
    output logic [4*DIGITS-1:0]          disp_bcd,
    output logic                         disp_neg,
    output logic                         disp_sel,
    output logic                         ovf,
    output logic [$clog2(DIGITS+1)-1:0]  entry_cnt
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    // Valid/ready: dig_vld and op_vld are single-cycle strobes with no back-pressure;
    // anything presented while busy (except CLR) is dropped, and op wins over dig.
    state_t         state;
    logic [W-1:0]   acc_mag;
    logic           acc_neg;
    logic [W-1:0]   entry;
    logic [CW-1:0]  cnt_q;
    logic           pend_sub;
    logic           eq_done;
    logic           ovf_q;
    logic           ovf_pend;
    logic           disp_sel_q;

    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   res_sh;
    logic           res_neg;
    logic           sub_mode;
    logic           chain;
    logic [CW-1:0]  pos;
    logic [2:0]     op_q;

    bcd_digit_t     alu_a;
    bcd_digit_t     alu_b;
    bcd_digit_t     alu_y;
    logic           alu_sub;
    logic           alu_cout;
    logic           last_digit;
    logic           clr_now;
    logic           arith_op;
    logic [W-1:0]   res_next;

    // The NEGP pass computes 0 - result, which is the ten's complement.
    always_comb begin
        alu_a   = a_sh[3:0];
        alu_b   = b_sh[3:0];
        alu_sub = sub_mode;
        if (state == ST_NEGP) begin
            alu_a   = 4'd0;
            alu_b   = res_sh[3:0];
            alu_sub = 1'b1;
        end
    end

    bcd_digit_alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .sub  (alu_sub),
        .cin  (chain),
        .y    (alu_y),
        .cout (alu_cout)
    );

    assign last_digit = (pos == CW'(DIGITS - 1));
    assign clr_now    = op_vld && (op == OP_CLR);
    assign arith_op   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_EQ);
    assign res_next   = (res_sh >> 4) | (W'(alu_y) << (W - 4));

    always_ff @(posedge clk) begin
        if (!rst || clr_now) begin
            state      <= ST_IDLE;
            acc_mag    <= '0;
            acc_neg    <= 1'b0;
            entry      <= '0;
            cnt_q      <= '0;
            pend_sub   <= 1'b0;
            eq_done    <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_pend   <= 1'b0;
            disp_sel_q <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            res_neg    <= 1'b0;
            sub_mode   <= 1'b0;
            chain      <= 1'b0;
            pos        <= '0;
            op_q       <= OP_ADD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_vld) begin
                        if (!ovf_q && arith_op) begin
                            if (cnt_q == '0 && disp_sel_q) begin
                                if (op != OP_EQ) pend_sub <= (op == OP_SUB);
                            end else begin
                                a_sh     <= acc_mag;
                                b_sh     <= entry;
                                res_sh   <= '0;
                                sub_mode <= acc_neg ^ pend_sub;
                                res_neg  <= acc_neg;
                                op_q     <= op;
                                chain    <= 1'b0;
                                ovf_pend <= 1'b0;
                                pos      <= '0;
                                state    <= ST_ADDP;
                            end
                        end
`ifdef CALC_BACKSPACE_EN
                        else if (!ovf_q && op == OP_BKSP && cnt_q != '0) begin
                            entry <= entry >> 4;
                            cnt_q <= cnt_q - 1'b1;
                        end
`endif
                    end else if (dig_vld && !ovf_q && dig <= 4'd9) begin
                        if (eq_done) begin
                            acc_mag <= '0;
                            acc_neg <= 1'b0;
                            eq_done <= 1'b0;
                        end
                        if (cnt_q < CW'(DIGITS)) begin
                            entry      <= (entry << 4) | W'(dig);
                            disp_sel_q <= 1'b0;
                            if (!(dig == 4'd0 && cnt_q == '0)) cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                ST_ADDP: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    chain  <= alu_cout;
                    pos    <= pos + 1'b1;
                    if (last_digit) begin
                        chain <= 1'b0;
                        pos   <= '0;
                        // A final borrow means |entry| > |acc|: complement and flip sign.
                        if (sub_mode && alu_cout) begin
                            res_neg <= ~res_neg;
                            state   <= ST_NEGP;
                        end else begin
                            ovf_pend <= !sub_mode && alu_cout;
                            state    <= ST_DONE;
                        end
                    end
                end

                ST_NEGP: begin
                    res_sh <= res_next;
                    chain  <= alu_cout;
                    pos    <= pos + 1'b1;
                    if (last_digit) begin
                        chain <= 1'b0;
                        pos   <= '0;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    acc_mag    <= res_sh;
                    acc_neg    <= res_neg && (res_sh != '0);
                    ovf_q      <= ovf_q | ovf_pend;
                    entry      <= '0;
                    cnt_q      <= '0;
                    disp_sel_q <= 1'b1;
                    pend_sub   <= (op_q == OP_SUB);
                    eq_done    <= (op_q == OP_EQ);
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign disp_bcd  = disp_sel_q ? acc_mag : entry;
    assign disp_neg  = disp_sel_q & acc_neg;
    assign disp_sel  = disp_sel_q;
    assign ovf       = ovf_q;
    assign entry_cnt = cnt_q;

endmodule

// File: tb/tb_bcd_accumulator.sv
// Bench for bcd_accumulator (DIGITS=4): directed key sequences plus random key
// traffic, checked against an integer-arithmetic calculator model.
module tb_bcd_accumulator;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam longint LIMIT = 10000;

    localparam logic [2:0] K_ADD  = 3'd0;
    localparam logic [2:0] K_SUB  = 3'd1;
    localparam logic [2:0] K_EQ   = 3'd2;
    localparam logic [2:0] K_CLR  = 3'd3;
    localparam logic [2:0] K_BKSP = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dig_vld = 1'b0;
    logic [3:0]    dig = '0;
    logic          op_vld = 1'b0;
    logic [2:0]    op = '0;
    logic          busy;
    logic [W-1:0]  disp_bcd;
    logic          disp_neg;
    logic          disp_sel;
    logic          ovf;
    logic [CW-1:0] entry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];

    // Reference calculator state as plain integers.
    longint m_acc;
    longint m_entry;
    int     m_cnt;
    bit     m_sel;
    bit     m_pend_sub;
    bit     m_eq;
    bit     m_ovf;
    int     m_lat;

    bcd_accumulator #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .dig_vld   (dig_vld),
        .dig       (dig),
        .op_vld    (op_vld),
        .op        (op),
        .busy      (busy),
        .disp_bcd  (disp_bcd),
        .disp_neg  (disp_neg),
        .disp_sel  (disp_sel),
        .ovf       (ovf),
        .entry_cnt (entry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic longint mag(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r;
        longint t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_entry = 0; m_cnt = 0; m_sel = 0;
        m_pend_sub = 0; m_eq = 0; m_ovf = 0; m_lat = 0;
    endtask

    task automatic model_dig(input int d);
        m_lat = 0;
        if (m_ovf || d > 9) return;
        if (m_eq) begin
            m_acc = 0;
            m_eq  = 0;
        end
        if (m_cnt < DIGITS) begin
            m_entry = m_entry * 10 + d;
            if (!(d == 0 && m_cnt == 0)) m_cnt++;
            m_sel = 0;
        end
    endtask

    task automatic model_op(input int o);
        longint r;
        longint rm;
        bit differ;
        m_lat = 0;
        if (o == K_CLR) begin
            model_reset();
            return;
        end
        if (m_ovf) return;
        if (o == K_ADD || o == K_SUB || o == K_EQ) begin
            if (m_cnt == 0 && m_sel) begin
                if (o != K_EQ) m_pend_sub = (o == K_SUB);
                return;
            end
            differ = (m_acc < 0) != m_pend_sub;
            m_lat  = (differ && mag(m_acc) < m_entry) ? 2 * DIGITS + 1 : DIGITS + 1;
            r  = m_pend_sub ? m_acc - m_entry : m_acc + m_entry;
            rm = mag(r);
            if (rm >= LIMIT) begin
                m_ovf = 1;
                rm = rm % LIMIT;
            end
            m_acc   = (r < 0) ? -rm : rm;
            m_entry = 0;
            m_cnt   = 0;
            m_sel   = 1;
            m_pend_sub = (o == K_SUB);
            m_eq       = (o == K_EQ);
        end
`ifdef CALC_BACKSPACE_EN
        else if (o == K_BKSP && m_cnt > 0) begin
            m_entry = m_entry / 10;
            m_cnt--;
        end
`endif
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] e;
        exp_q.push_back(to_bcd(m_sel ? mag(m_acc) : m_entry));
        e = exp_q.pop_front();
        check({tag, ".bcd"}, 32'(disp_bcd), 32'(e));
        check({tag, ".neg"}, 32'(disp_neg), 32'(m_sel && m_acc < 0));
        check({tag, ".sel"}, 32'(disp_sel), 32'(m_sel));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, ".cnt"}, 32'(entry_cnt), 32'(m_cnt));
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // One key event; optional noise injects a digit and an op mid-computation.
    task automatic do_step(input string tag, input bit dv, input logic [3:0] d,
                           input bit ov, input logic [2:0] o, input bit noise);
        int n;
        @(negedge clk);
        dig_vld = dv; dig = d; op_vld = ov; op = o;
        @(negedge clk);
        dig_vld = 0; op_vld = 0;
        if (ov) model_op(int'(o));
        else if (dv) model_dig(int'(d));
        else m_lat = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (noise && n == 2) begin
                dig_vld = 1; dig = 4'd7;
            end else if (noise && n == 3) begin
                op_vld = 1; op = K_SUB;
            end
            @(negedge clk);
            dig_vld = 0; op_vld = 0;
        end
        check({tag, ".lat"}, 32'(n), 32'(m_lat));
        check_outputs(tag);
    endtask

    task automatic dkey(input int d);
        do_step("dig", 1'b1, 4'(d), 1'b0, 3'd0, 1'b0);
    endtask

    task automatic okey(input logic [2:0] o);
        do_step("op", 1'b0, 4'd0, 1'b1, o, 1'b0);
    endtask

    task automatic abort_run(input bit by_rst);
        dkey(9); dkey(8);
        @(negedge clk);
        op_vld = 1; op = K_ADD;
        @(negedge clk);
        op_vld = 0;
        check("abort.busy_on", 32'(busy), 32'd1);
        @(negedge clk);
        if (by_rst) rst = 0;
        else begin
            op_vld = 1; op = K_CLR;
        end
        @(negedge clk);
        rst = 1; op_vld = 0;
        model_reset();
        check_outputs(by_rst ? "abort_rst" : "abort_clr");
        @(negedge clk);
        check("abort.idle", 32'(busy), 32'd0);
    endtask

    initial begin
        model_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst = 1;

        // 23 + 456 chain
        dkey(2); dkey(3); okey(K_ADD);
        check("tp1.first", 32'(disp_bcd), 32'h0023);
        dkey(4); dkey(5); dkey(6);
        do_step("tp1.noise", 1'b0, 4'd0, 1'b1, K_ADD, 1'b1);
        check("tp1.second", 32'(disp_bcd), 32'h0479);

        // 23 - 45 = -22, then a digit starts over
        okey(K_CLR);
        dkey(2); dkey(3); okey(K_SUB); dkey(4); dkey(5); okey(K_EQ);
        check("tp2.val", 32'(disp_bcd), 32'h0022);
        check("tp2.neg", 32'(disp_neg), 32'd1);
        dkey(7);
        check("tp2.after", 32'(disp_bcd), 32'h0007);
        okey(K_EQ);
        check("tp2.acc_cleared", 32'(disp_bcd), 32'h0007);

        // overflow and sticky lockout
        okey(K_CLR);
        dkey(9); dkey(9); dkey(9); dkey(9); okey(K_ADD); dkey(1); okey(K_EQ);
        check("tp3.ovf", 32'(ovf), 32'd1);
        check("tp3.val", 32'(disp_bcd), 32'h0000);
        dkey(3); okey(K_ADD);
        okey(K_CLR);
        check("tp3.clr", 32'(ovf), 32'd0);

        // entry saturation, invalid digit, simultaneous keys
        for (int i = 0; i < 5; i++) dkey(5);
        check("tp4.val", 32'(disp_bcd), 32'h5555);
        check("tp4.cnt", 32'(entry_cnt), 32'd4);
        dkey(11);
        do_step("tp4.both", 1'b1, 4'd3, 1'b1, K_ADD, 1'b0);

        // pending replacement without digits
        okey(K_CLR);
        dkey(8); okey(K_ADD); okey(K_SUB); dkey(3); okey(K_EQ);
        check("tp5.val", 32'(disp_bcd), 32'h0005);

        // leading zero does not count
        okey(K_CLR);
        dkey(0); dkey(0); dkey(4);
        check("lead0.cnt", 32'(entry_cnt), 32'd1);

        abort_run(1'b1);
        abort_run(1'b0);

        // backspace
        okey(K_CLR);
        dkey(1); dkey(2); dkey(3); okey(K_BKSP);
`ifdef CALC_BACKSPACE_EN
        check("bksp.val", 32'(disp_bcd), 32'h0012);
        check("bksp.cnt", 32'(entry_cnt), 32'd2);
`else
        check("bksp.val", 32'(disp_bcd), 32'h0123);
        check("bksp.cnt", 32'(entry_cnt), 32'd3);
`endif

        // random key traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            int d;
            logic [2:0] o;
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 99) < 88) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            o = 3'($urandom_range(0, 7));
            if (o == K_CLR) o = K_ADD;
            if (r < 3)
                do_step("rnd.clr", 1'b0, 4'd0, 1'b1, K_CLR, 1'b0);
            else if (r < 60)
                do_step("rnd.dig", 1'b1, 4'(d), 1'b0, 3'd0, 1'b0);
            else if (r < 92)
                do_step("rnd.op", 1'b0, 4'd0, 1'b1, o, r[0]);
            else
                do_step("rnd.both", 1'b1, 4'(d), 1'b1, o, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
